// File: rtl/svif_fanout_pkg.sv
// ---------------------------------------------------------------------------
// svif_fanout_pkg
// Purpose : shared types and constants for the isolated fan-out block.
//           Holds the per-sink isolation state enum, the default parameter
//           values used by svif_fanout_iso / svif_iso_sink_fsm, and the width
//           of the optional error counter (SVIF_ISO_ERRCNT_EN builds).
// Ports   : none (package)
// ---------------------------------------------------------------------------
package svif_fanout_pkg;

    // Per-sink isolation sequence state
    typedef enum logic [1:0] {
        ON    = 2'd0,
        ENTER = 2'd1,
        ISO   = 2'd2,
        EXIT  = 2'd3
    } sink_state_e;

    localparam int DEF_BIT_WIDTH     = 2;
    localparam int DEF_NUM_SINKS     = 3;
    localparam int DEF_SETTLE_CYCLES = 4;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/svif_iso_sink_fsm.sv
// ---------------------------------------------------------------------------
// svif_iso_sink_fsm
// Purpose : one sink power domain's isolation sequencer plus its registered
//           data/valid output. Walks ON -> ENTER -> ISO -> EXIT -> ON with a
//           settle counter timing the ENTER and EXIT phases.
// Macro   : SVIF_ISO_ERRCNT_EN adds the err_window output (sink in ENTER/ISO).
// Ports   : ck, arst (async active-low)    clock / reset
//           src_data, src_valid             source-domain data and qualifier
//           src_pwr_ok                      source domain powered
//           iso_req                         isolation request for this sink
//           iso_ack                         sink fully isolated (ISO state)
//           snk_iso                         isolation enable to the sink
//           snk_data, snk_valid             registered sink data / qualifier
//           err_window (optional)           sink is in ENTER or ISO
// ---------------------------------------------------------------------------
module svif_iso_sink_fsm
    import svif_fanout_pkg::*;
#(
    parameter int                   BIT_WIDTH     = DEF_BIT_WIDTH,
    parameter int                   SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter logic [BIT_WIDTH-1:0] CLAMP_VAL     = '0
) (
    input  logic                 ck,
    input  logic                 arst,
    input  logic [BIT_WIDTH-1:0] src_data,
    input  logic                 src_valid,
    input  logic                 src_pwr_ok,
    input  logic                 iso_req,
    output logic                 iso_ack,
    output logic                 snk_iso,
    output logic [BIT_WIDTH-1:0] snk_data,
    output logic                 snk_valid
`ifdef SVIF_ISO_ERRCNT_EN
    ,
    output logic                 err_window
`endif
);

    localparam int             CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    sink_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   isolate;

    // Loss of source power is treated exactly like an explicit request.
    assign isolate = iso_req || !src_pwr_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ON: begin
                if (isolate) begin
                    state_d = ENTER;
                    cnt_d   = '0;
                end
            end
            // ENTER cannot be aborted; it always runs to ISO.
            ENTER: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ISO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ISO: begin
                if (!isolate) begin
                    state_d = EXIT;
                    cnt_d   = '0;
                end
            end
            // A new request during EXIT restarts the full ENTER sequence.
            EXIT: begin
                if (isolate) begin
                    state_d = ENTER;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ISO;
                cnt_d   = '0;
            end
        endcase
    end

    // Data only passes while the sink is ON both before and after the edge,
    // so the first edge back into ON still shows the clamp value.
    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        if (state_d != ON) begin
            data_d = CLAMP_VAL;
        end else if ((state_q == ON) && src_valid) begin
            data_d  = src_data;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge ck or negedge arst) begin
        if (!arst) begin
            state_q <= ISO;
            cnt_q   <= '0;
            data_q  <= CLAMP_VAL;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign iso_ack   = (state_q == ISO);
    assign snk_iso   = (state_q != ON);
    assign snk_data  = data_q;
    assign snk_valid = valid_q;
`ifdef SVIF_ISO_ERRCNT_EN
    assign err_window = (state_q == ENTER) || (state_q == ISO);
`endif

endmodule

// File: rtl/svif_fanout_iso.sv
// ---------------------------------------------------------------------------
// svif_fanout_iso
// Purpose : fans one source-domain data vector out to NUM_SINKS independently
//           power-gated sink domains, each with its own isolation sequencer.
// Macro   : SVIF_ISO_ERRCNT_EN adds err_cnt, a saturating count of edges where
//           src_valid was high while any sink was entering or in isolation.
// Ports   : ck, arst (async active-low)    clock / reset
//           src_data, src_valid             source-domain data and qualifier
//           src_pwr_ok                      source domain powered
//           iso_req[NUM_SINKS]              per-sink isolation request
//           iso_ack[NUM_SINKS]              per-sink isolation complete
//           snk_iso[NUM_SINKS]              per-sink isolation enable
//           snk_data[NUM_SINKS*BIT_WIDTH]   sink i on [i*BIT_WIDTH +: BIT_WIDTH]
//           snk_valid[NUM_SINKS]            per-sink data qualifier
//           err_cnt[8] (optional)           saturating discarded-data count
// ---------------------------------------------------------------------------
module svif_fanout_iso
    import svif_fanout_pkg::*;
#(
    parameter int                   BIT_WIDTH     = DEF_BIT_WIDTH,
    parameter int                   NUM_SINKS     = DEF_NUM_SINKS,
    parameter int                   SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter logic [BIT_WIDTH-1:0] CLAMP_VAL     = '0
) (
    input  logic                           ck,
    input  logic                           arst,
    input  logic [BIT_WIDTH-1:0]           src_data,
    input  logic                           src_valid,
    input  logic                           src_pwr_ok,
    input  logic [NUM_SINKS-1:0]           iso_req,
    output logic [NUM_SINKS-1:0]           iso_ack,
    output logic [NUM_SINKS-1:0]           snk_iso,
    output logic [NUM_SINKS*BIT_WIDTH-1:0] snk_data,
    output logic [NUM_SINKS-1:0]           snk_valid
`ifdef SVIF_ISO_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0]           err_cnt
`endif
);

`ifdef SVIF_ISO_ERRCNT_EN
    logic [NUM_SINKS-1:0] err_window;
`endif

    for (genvar i = 0; i < NUM_SINKS; i++) begin : g_sink
        svif_iso_sink_fsm #(
            .BIT_WIDTH     (BIT_WIDTH),
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .CLAMP_VAL     (CLAMP_VAL)
        ) u_sink (
            .ck         (ck),
            .arst       (arst),
            .src_data   (src_data),
            .src_valid  (src_valid),
            .src_pwr_ok (src_pwr_ok),
            .iso_req    (iso_req[i]),
            .iso_ack    (iso_ack[i]),
            .snk_iso    (snk_iso[i]),
            .snk_data   (snk_data[i*BIT_WIDTH +: BIT_WIDTH]),
            .snk_valid  (snk_valid[i])
`ifdef SVIF_ISO_ERRCNT_EN
            ,
            .err_window (err_window[i])
`endif
        );
    end

`ifdef SVIF_ISO_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Counts source data that no isolated/isolating sink could accept.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (src_valid && (|err_window) && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge ck or negedge arst) begin
        if (!arst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_svif_fanout_iso.sv
// ---------------------------------------------------------------------------
// tb_svif_fanout_iso
// Purpose : directed self-checking bench for svif_fanout_iso at the default
//           configuration (BIT_WIDTH=2, NUM_SINKS=3, SETTLE_CYCLES=4,
//           CLAMP_VAL=0). Inputs are applied after a rising edge so they are
//           sampled on the next one; outputs are read 1 time unit after it.
// Macro   : SVIF_ISO_ERRCNT_EN enables the err_cnt scenario.
// ---------------------------------------------------------------------------
module tb_svif_fanout_iso;

    logic       ck;
    logic       arst;
    logic [1:0] src_data;
    logic       src_valid;
    logic       src_pwr_ok;
    logic [2:0] iso_req;
    logic [2:0] iso_ack;
    logic [2:0] snk_iso;
    logic [5:0] snk_data;
    logic [2:0] snk_valid;
`ifdef SVIF_ISO_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    svif_fanout_iso #(
        .BIT_WIDTH     (2),
        .NUM_SINKS     (3),
        .SETTLE_CYCLES (4),
        .CLAMP_VAL     (2'b00)
    ) dut (
        .ck         (ck),
        .arst       (arst),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_pwr_ok (src_pwr_ok),
        .iso_req    (iso_req),
        .iso_ack    (iso_ack),
        .snk_iso    (snk_iso),
        .snk_data   (snk_data),
        .snk_valid  (snk_valid)
`ifdef SVIF_ISO_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge ck);
        #1;
    endtask

    // Reset values, then release with no requests: EXIT on the first edge,
    // back to ON exactly four edges later.
    task automatic test_reset();
        logic [2:0] exp_iso;
        iso_req    = 3'b000;
        src_pwr_ok = 1'b1;
        src_valid  = 1'b0;
        src_data   = 2'b00;
        arst       = 1'b1;
        #2;
        arst = 1'b0;
        #1;
        n_vec++;
        if (iso_ack !== 3'b111) begin
            n_err++;
            $display("[TB] FAIL reset_ack: got %b want %b", iso_ack, 3'b111);
        end
        n_vec++;
        if (snk_iso !== 3'b111) begin
            n_err++;
            $display("[TB] FAIL reset_iso: got %b want %b", snk_iso, 3'b111);
        end
        n_vec++;
        if (snk_valid !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL reset_valid: got %b want %b", snk_valid, 3'b000);
        end
        n_vec++;
        if (snk_data !== 6'b000000) begin
            n_err++;
            $display("[TB] FAIL reset_data: got %b want %b", snk_data, 6'b000000);
        end
        step();
        step();
        arst = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            exp_iso = (e < 5) ? 3'b111 : 3'b000;
            n_vec++;
            if (snk_iso !== exp_iso) begin
                n_err++;
                $display("[TB] FAIL release_iso e%0d: got %b want %b", e, snk_iso, exp_iso);
            end
            n_vec++;
            if (iso_ack !== 3'b000) begin
                n_err++;
                $display("[TB] FAIL release_ack e%0d: got %b want %b", e, iso_ack, 3'b000);
            end
            n_vec++;
            if (snk_data !== 6'b000000) begin
                n_err++;
                $display("[TB] FAIL release_data e%0d: got %b want %b", e, snk_data, 6'b000000);
            end
        end
    endtask

    // One-cycle latency load with valid, hold without valid.
    task automatic test_passthrough();
        logic       v_tab [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0] d_tab [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        logic [5:0] x_tab [5] = '{6'b010101, 6'b101010, 6'b101010, 6'b000000, 6'b000000};
        logic [2:0] exp_v;
        for (int i = 0; i < 5; i++) begin
            src_valid = v_tab[i];
            src_data  = d_tab[i];
            step();
            exp_v = v_tab[i] ? 3'b111 : 3'b000;
            n_vec++;
            if (snk_data !== x_tab[i]) begin
                n_err++;
                $display("[TB] FAIL pass_data v%0d: got %b want %b", i, snk_data, x_tab[i]);
            end
            n_vec++;
            if (snk_valid !== exp_v) begin
                n_err++;
                $display("[TB] FAIL pass_valid v%0d: got %b want %b", i, snk_valid, exp_v);
            end
        end
    endtask

    // Pulse iso_req[1]; sinks 0 and 2 keep streaming 11.
    task automatic test_single_sink();
        logic [2:0] exp_iso, exp_ack, exp_v;
        logic [5:0] exp_d;
        src_valid = 1'b1;
        src_data  = 2'b11;
        iso_req   = 3'b010;
        for (int j = 0; j <= 10; j++) begin
            step();
            iso_req = 3'b000;
            exp_iso = (j <= 8) ? 3'b010 : 3'b000;
            exp_ack = (j == 4) ? 3'b010 : 3'b000;
            exp_v   = (j == 10) ? 3'b111 : 3'b101;
            exp_d   = (j == 10) ? 6'b111111 : 6'b110011;
            n_vec++;
            if (snk_iso !== exp_iso) begin
                n_err++;
                $display("[TB] FAIL single_iso k+%0d: got %b want %b", j, snk_iso, exp_iso);
            end
            n_vec++;
            if (iso_ack !== exp_ack) begin
                n_err++;
                $display("[TB] FAIL single_ack k+%0d: got %b want %b", j, iso_ack, exp_ack);
            end
            n_vec++;
            if (snk_valid !== exp_v) begin
                n_err++;
                $display("[TB] FAIL single_valid k+%0d: got %b want %b", j, snk_valid, exp_v);
            end
            n_vec++;
            if (snk_data !== exp_d) begin
                n_err++;
                $display("[TB] FAIL single_data k+%0d: got %b want %b", j, snk_data, exp_d);
            end
        end
    endtask

    // Source power loss isolates every sink on the same edge, then recovery.
    task automatic test_power_loss();
        logic [2:0] exp_ack, exp_iso;
        src_valid  = 1'b1;
        src_data   = 2'b01;
        src_pwr_ok = 1'b0;
        for (int j = 0; j <= 5; j++) begin
            step();
            exp_ack = (j >= 4) ? 3'b111 : 3'b000;
            n_vec++;
            if (snk_iso !== 3'b111) begin
                n_err++;
                $display("[TB] FAIL pwr_iso k+%0d: got %b want %b", j, snk_iso, 3'b111);
            end
            n_vec++;
            if (snk_valid !== 3'b000) begin
                n_err++;
                $display("[TB] FAIL pwr_valid k+%0d: got %b want %b", j, snk_valid, 3'b000);
            end
            n_vec++;
            if (snk_data !== 6'b000000) begin
                n_err++;
                $display("[TB] FAIL pwr_data k+%0d: got %b want %b", j, snk_data, 6'b000000);
            end
            n_vec++;
            if (iso_ack !== exp_ack) begin
                n_err++;
                $display("[TB] FAIL pwr_ack k+%0d: got %b want %b", j, iso_ack, exp_ack);
            end
        end
        src_valid  = 1'b0;
        src_pwr_ok = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            step();
            exp_iso = (j <= 4) ? 3'b111 : 3'b000;
            n_vec++;
            if (snk_iso !== exp_iso) begin
                n_err++;
                $display("[TB] FAIL pwr_recover_iso r%0d: got %b want %b", j, snk_iso, exp_iso);
            end
            n_vec++;
            if (iso_ack !== 3'b000) begin
                n_err++;
                $display("[TB] FAIL pwr_recover_ack r%0d: got %b want %b", j, iso_ack, 3'b000);
            end
        end
    endtask

    // iso_req[0] returns two edges into EXIT: ENTER restarts, isolation
    // never drops.
    task automatic test_exit_reentry();
        logic [2:0] exp_iso, exp_ack;
        src_valid = 1'b0;
        for (int j = 0; j <= 16; j++) begin
            iso_req = ((j == 0) || (j == 7)) ? 3'b001 : 3'b000;
            step();
            exp_iso = (j <= 15) ? 3'b001 : 3'b000;
            exp_ack = ((j == 4) || (j == 11)) ? 3'b001 : 3'b000;
            n_vec++;
            if (snk_iso !== exp_iso) begin
                n_err++;
                $display("[TB] FAIL reentry_iso a+%0d: got %b want %b", j, snk_iso, exp_iso);
            end
            n_vec++;
            if (iso_ack !== exp_ack) begin
                n_err++;
                $display("[TB] FAIL reentry_ack a+%0d: got %b want %b", j, iso_ack, exp_ack);
            end
        end
        iso_req = 3'b000;
    endtask

    // All sinks requested together, then reset lands two edges into ENTER.
    task automatic test_reset_mid_enter();
        logic [2:0] exp_iso;
        iso_req = 3'b111;
        step();
        iso_req = 3'b000;
        n_vec++;
        if (snk_iso !== 3'b111) begin
            n_err++;
            $display("[TB] FAIL parallel_enter_iso: got %b want %b", snk_iso, 3'b111);
        end
        n_vec++;
        if (iso_ack !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL parallel_enter_ack: got %b want %b", iso_ack, 3'b000);
        end
        step();
        step();
        src_valid = 1'b1;
        src_data  = 2'b10;
        #2;
        arst = 1'b0;
        #1;
        n_vec++;
        if (iso_ack !== 3'b111) begin
            n_err++;
            $display("[TB] FAIL midenter_ack: got %b want %b", iso_ack, 3'b111);
        end
        n_vec++;
        if (snk_data !== 6'b000000) begin
            n_err++;
            $display("[TB] FAIL midenter_data: got %b want %b", snk_data, 6'b000000);
        end
        n_vec++;
        if (snk_valid !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL midenter_valid: got %b want %b", snk_valid, 3'b000);
        end
        step();
        arst      = 1'b1;
        src_valid = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            step();
            exp_iso = (j <= 4) ? 3'b111 : 3'b000;
            n_vec++;
            if (snk_iso !== exp_iso) begin
                n_err++;
                $display("[TB] FAIL midenter_exit_iso r%0d: got %b want %b", j, snk_iso, exp_iso);
            end
            n_vec++;
            if (iso_ack !== 3'b000) begin
                n_err++;
                $display("[TB] FAIL midenter_exit_ack r%0d: got %b want %b", j, iso_ack, 3'b000);
            end
        end
    endtask

`ifdef SVIF_ISO_ERRCNT_EN
    // Sink 2 held isolated while src_valid stays high for 300 edges.
    task automatic test_err_cnt();
        logic [7:0] exp_cnt;
        step();
        arst = 1'b0;
        #1;
        n_vec++;
        if (err_cnt !== 8'd0) begin
            n_err++;
            $display("[TB] FAIL errcnt_reset: got %0d want %0d", err_cnt, 0);
        end
        step();
        arst      = 1'b1;
        iso_req   = 3'b100;
        src_valid = 1'b1;
        src_data  = 2'b01;
        for (int n = 1; n <= 300; n++) begin
            step();
            if ((n == 10) || (n == 255) || (n == 300)) begin
                exp_cnt = (n >= 255) ? 8'd255 : 8'(n);
                n_vec++;
                if (err_cnt !== exp_cnt) begin
                    n_err++;
                    $display("[TB] FAIL errcnt n%0d: got %0d want %0d", n, err_cnt, exp_cnt);
                end
            end
        end
        iso_req   = 3'b000;
        src_valid = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_single_sink();
        test_power_loss();
        test_exit_reentry();
        test_reset_mid_enter();
`ifdef SVIF_ISO_ERRCNT_EN
        test_err_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/svif_fanout_iso.md
SVIF_FANOUT_ISO -- requirements
Module: svif_fanout_iso

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 2, the width of the fanned-out signal vector.
REQ-002 The block SHALL have parameter NUM_SINKS, default 3, the number of sink power domains (legal range 1-16).
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 4, the isolation enter/exit settle time in ck cycles (legal range 1-255).
REQ-004 The block SHALL have parameter CLAMP_VAL, default '0, the BIT_WIDTH-wide value driven on isolated sinks.
REQ-005 The block SHALL have port ck, input, 1 bit, the single clock.
REQ-006 The block SHALL have port arst, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port src_data, input, BIT_WIDTH bits, source-domain data.
REQ-008 The block SHALL have port src_valid, input, 1 bit, src_data qualifier.
REQ-009 The block SHALL have port src_pwr_ok, input, 1 bit, high while the source (least-on) domain is powered.
REQ-010 The block SHALL have port iso_req, input, NUM_SINKS bits, per-sink isolation request.
REQ-011 The block SHALL have port iso_ack, output, NUM_SINKS bits, per-sink isolation-complete acknowledge.
REQ-012 The block SHALL have port snk_iso, output, NUM_SINKS bits, per-sink isolation-enable to the sink domain.
REQ-013 The block SHALL have port snk_data, output, NUM_SINKS*BIT_WIDTH bits, with sink i on slice [i*BIT_WIDTH +: BIT_WIDTH].
REQ-014 The block SHALL have port snk_valid, output, NUM_SINKS bits, per-sink data qualifier.

Function
REQ-015 Each sink SHALL run an independent FSM with states ON, ENTER, ISO and EXIT, plus a settle counter of width $clog2(SETTLE_CYCLES+1).
REQ-016 In ON, if iso_req[i]=1 or src_pwr_ok=0 at an edge, the FSM SHALL move to ENTER at that edge: snk_iso[i]=1 and snk_valid[i]=0 from that edge, and the counter loads 0.
REQ-017 ENTER SHALL last exactly SETTLE_CYCLES cycles, then move to ISO with iso_ack[i]=1; iso_ack[i] rises SETTLE_CYCLES edges after the ENTER edge.
REQ-018 In ISO, when iso_req[i]=0 and src_pwr_ok=1 at an edge, the FSM SHALL move to EXIT with iso_ack[i]=0 and snk_iso[i] held at 1.
REQ-019 EXIT SHALL last exactly SETTLE_CYCLES cycles, then move to ON with snk_iso[i]=0.
REQ-020 In ENTER, deassertion of iso_req[i] SHALL NOT abort the sequence; ENTER completes to ISO, and ISO exits normally on the next qualifying edge.
REQ-021 In EXIT, iso_req[i]=1 or src_pwr_ok=0 SHALL return the FSM to ENTER with the counter reloaded to 0.
REQ-022 In ON, at each edge with src_valid=1, snk_data slice i SHALL load src_data and snk_valid[i] SHALL be 1 (one-cycle latency).
REQ-023 In ON, at each edge with src_valid=0, snk_valid[i] SHALL be 0 and snk_data slice i SHALL hold its value.
REQ-024 In ENTER, ISO and EXIT, snk_data slice i SHALL equal CLAMP_VAL and snk_valid[i] SHALL be 0.
REQ-025 When src_pwr_ok falls, all sinks in ON SHALL enter ENTER on the same edge, independent of iso_req.
REQ-026 Sinks SHALL NOT interact; simultaneous requests on all sinks SHALL be serviced in parallel with identical timing.

Reset
REQ-027 Assertion of arst (low) SHALL asynchronously force every sink to ISO with iso_ack=all-ones, snk_iso=all-ones, snk_valid=0, snk_data=all CLAMP_VAL and counters=0.
REQ-028 Reset asserted mid-ENTER or mid-EXIT SHALL discard the sequence; after release each sink leaves ISO only through EXIT.
REQ-029 Reset deassertion SHALL be used synchronously to ck.

Configuration
REQ-030 With macro SVIF_ISO_ERRCNT_EN defined, the block SHALL add output err_cnt (8 bits, saturating at 255, reset 0), incremented once for each edge where src_valid=1 while any sink is in ENTER or ISO.
REQ-031 Without SVIF_ISO_ERRCNT_EN, port err_cnt and its logic SHALL be absent.

Structure
REQ-032 Package svif_fanout_pkg SHALL hold the sink state enum (ON, ENTER, ISO, EXIT), the default parameter constants, and the err_cnt width constant.
REQ-033 Per-sink FSM, counter and output register SHALL be sub-module svif_iso_sink_fsm, instantiated NUM_SINKS times in a generate loop.

Verification
REQ-034 The bench SHALL cover reset release: with BIT_WIDTH=2, NUM_SINKS=3, SETTLE_CYCLES=4, iso_req=000 and src_pwr_ok=1, all snk_iso SHALL fall exactly 4 edges after the first edge, with snk_data=00 throughout.
REQ-035 The bench SHALL cover single-sink isolation: iso_req=010 pulsed high at edge k SHALL give snk_iso[1]=1 at k and iso_ack[1]=1 at k+4, while sinks 0 and 2 pass src_data=11 with one-cycle latency.
REQ-036 The bench SHALL cover source power loss: src_pwr_ok=0 at edge k SHALL give snk_iso=111 at k, snk_valid=000, and iso_ack=111 at k+4.
REQ-037 The bench SHALL cover re-entry during EXIT: iso_req[0] reasserted 2 edges into EXIT SHALL give ENTER restart and iso_ack[0]=1 4 edges later, with snk_iso[0] never low.
REQ-038 The bench SHALL cover reset mid-ENTER: arst low 2 edges into ENTER SHALL give immediate iso_ack=111 and snk_data=CLAMP_VAL.
REQ-039 The bench SHALL cover the error counter: with SVIF_ISO_ERRCNT_EN defined and src_valid=1 held for 300 cycles while sink 2 is isolated, err_cnt SHALL saturate at 255.
